// File: rtl/param_mem_pkg.sv
// Shared constants, response record and credit helper for param_mem.
package param_mem_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_RD_LAT = 1;

  // Response record at the default width; the top re-declares it at DATA_W.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] rdata;
    logic                  err;
  } rsp_t;

  // One queue slot per pipeline stage plus one, so reads never stall
  // while the consumer keeps rsp_ready high.
  function automatic int rsp_depth(input int rd_lat);
    return rd_lat + 1;
  endfunction

endpackage

// File: rtl/param_mem_rsp_fifo.sv
// Small first-word-fall-through queue holding read responses.
module param_mem_rsp_fifo
  import param_mem_pkg::*;
#(
  parameter type T     = rsp_t,
  parameter int  DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  T                           i_data,
  input  logic                       i_pop,
  output T                           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_cnt != '0);
  assign w_push = i_push && (w_pop || (r_cnt != FULL));
  assign o_data  = r_mem[r_rp];
  assign o_count = r_cnt;

  // Storage: written on push, never reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  // Pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= (r_wp == LAST) ? '0 : r_wp + PTR_W'(1);
      if (w_pop)  r_rp <= (r_rp == LAST) ? '0 : r_rp + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/param_mem.sv
// Single-port scratchpad with byte-lane writes, RD_LAT read pipeline and
// a credit-limited response queue.
module param_mem
  import param_mem_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter int                RD_LAT   = DEF_RD_LAT,
  parameter logic [DATA_W-1:0] INIT_VAL = '1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int BE_W      = DATA_W / 8;
  localparam int RSP_DEPTH = rsp_depth(RD_LAT);
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W-1:0]  CREDITS   = CNT_W'(RSP_DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_w_t;

  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: INIT_VAL};

  logic              w_in_range;
  logic              w_acc;
  logic              w_wr;
  logic              w_rd;
  rsp_w_t            w_rd_rsp;
  logic [RD_LAT-1:0] r_pv;
  rsp_w_t            r_pd [RD_LAT];
  logic              w_pipe_v;
  rsp_w_t            w_pipe_d;
  logic [CNT_W-1:0]  r_out;
  logic [CNT_W-1:0]  w_fifo_cnt;
  rsp_w_t            w_fifo_d;
  logic              w_fifo_nempty;
  logic              w_push;
  logic              w_pop;
  logic              w_rsp_fire;

  // Credit gate depends only on registered state and reset.
  assign req_ready  = !reset && (r_out < CREDITS);
  assign w_in_range = ({1'b0, req_addr} < DEPTH_LIM);
  assign w_acc      = req_valid && req_ready;
  assign w_wr       = w_acc && req_we && w_in_range;
  assign w_rd       = w_acc && !req_we;

  // Byte-lane write into the array; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (req_be[b]) r_mem[req_addr][b*8 +: 8] <= req_wdata[b*8 +: 8];
      end
    end
  end

  // Read data as sampled at the accept edge; out-of-range reads return zero.
  always_comb begin
    w_rd_rsp.rdata = '0;
    w_rd_rsp.err   = 1'b1;
    if (w_in_range) begin
      w_rd_rsp.rdata = r_mem[req_addr];
      w_rd_rsp.err   = 1'b0;
    end
  end

  // Valid shift pipeline, cleared by reset so in-flight reads are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pv <= '0;
    end else begin
      for (int s = RD_LAT - 1; s > 0; s--) r_pv[s] <= r_pv[s-1];
      r_pv[0] <= w_rd;
    end
  end

  // Data shift pipeline; qualified by r_pv so it needs no reset.
  always_ff @(posedge clk) begin
    for (int s = RD_LAT - 1; s > 0; s--) r_pd[s] <= r_pd[s-1];
    r_pd[0] <= w_rd_rsp;
  end

  assign w_pipe_v = r_pv[RD_LAT-1];
  assign w_pipe_d = r_pd[RD_LAT-1];

  // The last pipeline stage bypasses the queue when it is empty and the
  // consumer is ready; otherwise it is parked in the queue, which keeps
  // the presented response stable and gives exactly RD_LAT latency.
  assign w_fifo_nempty = (w_fifo_cnt != '0);
  assign w_pop         = w_fifo_nempty && rsp_ready;
  assign w_push        = w_pipe_v && !(!w_fifo_nempty && rsp_ready);

  param_mem_rsp_fifo #(
    .T     (rsp_w_t),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_pipe_d),
    .i_pop   (w_pop),
    .o_data  (w_fifo_d),
    .o_count (w_fifo_cnt)
  );

  assign rsp_valid  = w_pipe_v || w_fifo_nempty;
  assign w_rsp_fire = rsp_valid && rsp_ready;

  // Response mux: queue head has priority, zero when nothing is presented.
  always_comb begin
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    if (w_fifo_nempty) begin
      rsp_rdata = w_fifo_d.rdata;
      rsp_err   = w_fifo_d.err;
    end else if (w_pipe_v) begin
      rsp_rdata = w_pipe_d.rdata;
      rsp_err   = w_pipe_d.err;
    end
  end

  // Outstanding reads: accepted but not yet handed to the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
    end else begin
      case ({w_rd, w_rsp_fire})
        2'b10:   r_out <= r_out + CNT_W'(1);
        2'b01:   r_out <= r_out - CNT_W'(1);
        default: r_out <= r_out;
      endcase
    end
  end

endmodule

// File: tb/tb_param_mem.sv
module tb_param_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_a, valid_b;
  logic        req_we;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready;

  logic        req_ready_a, rsp_valid_a, rsp_err_a;
  logic [7:0]  rsp_rdata_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_b;

  logic        cur;
  logic        m_valid, m_req_ready, m_rsp_valid, m_rsp_err;
  logic [31:0] m_rsp_rdata;

  int          cyc = 0;
  int          n_tot = 0;
  int          n_bad = 0;
  int          n_stall;
  int          n_acc;
  logic        ok;

  logic [32:0] r_q[$];
  int          r_cyc[$];
  int          a_cyc[$];
  logic [32:0] exp_q[$];
  logic [7:0]  mdl_a [16];
  logic [31:0] mdl_b [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  param_mem u_a (
    .clk       (clk),
    .reset     (reset),
    .req_valid (valid_a),
    .req_ready (req_ready_a),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata[7:0]),
    .req_be    (req_be[0:0]),
    .rsp_valid (rsp_valid_a),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata_a),
    .rsp_err   (rsp_err_a)
  );

  param_mem #(
    .DATA_W (32),
    .ADDR_W (4),
    .DEPTH  (12),
    .RD_LAT (2)
  ) u_b (
    .clk       (clk),
    .reset     (reset),
    .req_valid (valid_b),
    .req_ready (req_ready_b),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid_b),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata_b),
    .rsp_err   (rsp_err_b)
  );

  assign m_valid     = cur ? valid_b     : valid_a;
  assign m_req_ready = cur ? req_ready_b : req_ready_a;
  assign m_rsp_valid = cur ? rsp_valid_b : rsp_valid_a;
  assign m_rsp_err   = cur ? rsp_err_b   : rsp_err_a;
  assign m_rsp_rdata = cur ? rsp_rdata_b : {24'h0, rsp_rdata_a};

  // Record accepted reads and delivered responses of the selected DUT.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_valid && m_req_ready && !req_we) a_cyc.push_back(cyc);
      if (m_rsp_valid && rsp_ready) begin
        r_q.push_back({m_rsp_err, m_rsp_rdata});
        r_cyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    r_q.delete();
    r_cyc.delete();
    a_cyc.delete();
    exp_q.delete();
  endtask

  task automatic send(input logic we, input logic [3:0] addr,
                      input logic [31:0] wd, input logic [3:0] be);
    int k;
    int dep;
    logic [32:0] e;
    req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    if (cur) valid_b = 1'b1; else valid_a = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (m_req_ready) break;
      n_stall++;
      @(posedge clk); #1;
    end
    if (k == 50) chk("send_timeout", 33'(k), 33'd0);
    @(posedge clk); #1;
    valid_a = 1'b0; valid_b = 1'b0;
    dep = cur ? 12 : 16;
    if (we) begin
      if (int'(addr) < dep) begin
        for (int l = 0; l < 4; l++) begin
          if (be[l]) begin
            if (cur) mdl_b[addr][l*8 +: 8] = wd[l*8 +: 8];
            else if (l == 0) mdl_a[addr] = wd[7:0];
          end
        end
      end
    end else begin
      if (int'(addr) >= dep) e = {1'b1, 32'h0};
      else if (cur) e = {1'b0, mdl_b[addr]};
      else e = {1'b0, 24'h0, mdl_a[addr]};
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_rsp(input int n);
    for (int k = 0; k < 400 && r_q.size() < n; k++) @(posedge clk);
    #1;
  endtask

  task automatic bp_step();
    @(negedge clk);
    ok = m_req_ready;
    @(posedge clk); #1;
    if (ok) begin
      n_acc++;
      req_addr = 4'(n_acc);
      if (n_acc == 5) valid_b = 1'b0;
    end
  endtask

  task automatic stream(input logic sel, input int lat);
    cur = sel; clr(); n_stall = 0; rsp_ready = 1'b1;
    for (int i = 0; i < 100; i++)
      send(1'b0, 4'($urandom_range(0, sel ? 11 : 15)), 32'h0, 4'h0);
    wait_rsp(100);
    chk($sformatf("stream%0d_stall", lat), 33'(n_stall), 33'd0);
    chk($sformatf("stream%0d_count", lat), 33'(r_q.size()), 33'd100);
    for (int i = 0; i < 100 && i < r_q.size(); i++) begin
      chk($sformatf("stream%0d_data%0d", lat, i), r_q[i], exp_q[i]);
      chk($sformatf("stream%0d_lat%0d", lat, i), 33'(r_cyc[i] - a_cyc[i]), 33'(lat));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mdl_a[i] = 8'hFF;
      mdl_b[i] = 32'hFFFF_FFFF;
    end
    reset = 1'b1; valid_a = 1'b0; valid_b = 1'b0; cur = 1'b0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b1;

    // Reset state.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready_a", 33'(req_ready_a), 33'd0);
    chk("rst_ready_b", 33'(req_ready_b), 33'd0);
    chk("rst_rsp_a", {rsp_valid_a, rsp_err_a, 24'h0, rsp_rdata_a}, 33'd0);
    chk("rst_rsp_b", {rsp_valid_b, rsp_err_b, rsp_rdata_b}, 33'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_a", 33'(req_ready_a), 33'd1);
    chk("post_rst_ready_b", 33'(req_ready_b), 33'd1);
    @(posedge clk); #1;

    // Initial content of the 8-bit, 16-word instance.
    cur = 1'b0; clr();
    for (int i = 0; i < 16; i++) send(1'b0, 4'(i), 32'h0, 4'h0);
    wait_rsp(16);
    chk("init_count", 33'(r_q.size()), 33'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("init%0d", i), r_q[i], {1'b0, 32'h0000_00FF});

    // Byte enables, read-after-write and a be=0 no-op write.
    cur = 1'b1; clr();
    send(1'b1, 4'd3, 32'h1122_3344, 4'b1111);
    send(1'b1, 4'd3, 32'hAABB_CCDD, 4'b0101);
    send(1'b0, 4'd3, 32'h0, 4'h0);
    send(1'b1, 4'd3, 32'h0000_0000, 4'b0000);
    send(1'b0, 4'd3, 32'h0, 4'h0);
    wait_rsp(2);
    chk("be_raw", r_q[0], {1'b0, 32'h11BB_33DD});
    chk("be_zero_noop", r_q[1], {1'b0, 32'h11BB_33DD});

    // Out-of-range on the 12-word instance.
    clr();
    send(1'b1, 4'd13, 32'h0000_005A, 4'b1111);
    send(1'b0, 4'd13, 32'h0, 4'h0);
    send(1'b0, 4'd12, 32'h0, 4'h0);
    send(1'b0, 4'd11, 32'h0, 4'h0);
    wait_rsp(3);
    chk("oor_13", r_q[0], {1'b1, 32'h0});
    chk("oor_12", r_q[1], {1'b1, 32'h0});
    chk("oor_11", r_q[2], {1'b0, 32'hFFFF_FFFF});

    // Back-pressure with RD_LAT=2: three credits.
    for (int i = 0; i < 5; i++) send(1'b1, 4'(i), 32'hC0DE_0000 + 32'(i), 4'b1111);
    clr();
    rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = 4'd0; valid_b = 1'b1; n_acc = 0;
    repeat (8) bp_step();
    chk("bp_accepted", 33'(n_acc), 33'd3);
    @(negedge clk);
    chk("bp_ready_low", 33'(req_ready_b), 33'd0);
    chk("bp_head", {rsp_valid_b, rsp_rdata_b}, {1'b1, 32'hC0DE_0000});
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hold", 33'(req_ready_b), 33'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 20 && n_acc < 5; k++) begin
      if (k == 0) begin
        @(negedge clk);
        chk("bp_reopen", 33'(req_ready_b), 33'd1);
        ok = req_ready_b;
        @(posedge clk); #1;
        if (ok) begin n_acc++; req_addr = 4'(n_acc); end
      end else begin
        bp_step();
      end
    end
    valid_b = 1'b0;
    chk("bp_total", 33'(n_acc), 33'd5);
    wait_rsp(5);
    chk("bp_count", 33'(r_q.size()), 33'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("bp_order%0d", i), r_q[i], {1'b0, 32'hC0DE_0000 + 32'(i)});

    // Reset with two reads in flight on the RD_LAT=1 instance.
    cur = 1'b0;
    send(1'b1, 4'd5, 32'h0000_003C, 4'b0001);
    send(1'b1, 4'd6, 32'h0000_0099, 4'b0001);
    rsp_ready = 1'b0;
    send(1'b0, 4'd5, 32'h0, 4'h0);
    send(1'b0, 4'd6, 32'h0, 4'h0);
    clr();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 33'(req_ready_a), 33'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_rsp", {rsp_valid_a, rsp_err_a, 24'h0, rsp_rdata_a}, 33'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_dropped", 33'(r_q.size()), 33'd0);
    send(1'b0, 4'd5, 32'h0, 4'h0);
    send(1'b0, 4'd6, 32'h0, 4'h0);
    wait_rsp(2);
    chk("midrst_keep5", r_q[0], {1'b0, 32'h0000_003C});
    chk("midrst_keep6", r_q[1], {1'b0, 32'h0000_0099});

    // Streaming, both latencies.
    stream(1'b0, 1);
    stream(1'b1, 2);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
